// File: rtl/xnor_prbs_checker_if.sv
// Stream-in / status-out bundle for the XNOR PRBS checker.
// The master side (source / testbench) drives the serial stream and counter clear.
// The slave side (checker) returns lock status, error pulses and the error count.
interface xnor_prbs_checker_if #(
  parameter int ERR_W = 16
);
  logic             in_valid;
  logic             in_bit;
  logic             clear_cnt;
  logic             locked;
  logic             err_pulse;
  logic             lock_lost;
  logic [ERR_W-1:0] err_count;

  modport master (
    output in_valid, in_bit, clear_cnt,
    input  locked, err_pulse, lock_lost, err_count
  );

  modport slave (
    input  in_valid, in_bit, clear_cnt,
    output locked, err_pulse, lock_lost, err_count
  );
endinterface

// File: rtl/xnor_prbs_checker.sv
// Serial PRBS checker for an XNOR-feedback LFSR stream.
// It self-seeds from the incoming bits and qualifies lock over a run of correct
// predictions. Once locked, it free-runs its own LFSR and counts bit errors.
module xnor_prbs_checker #(
  parameter int POLY_LEN   = 7,
  parameter int TAP_B      = 6,
  parameter int LOCK_COUNT = 16,
  parameter int LOSS_COUNT = 4,
  parameter int ERR_W      = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  xnor_prbs_checker_if.slave  bus
);

  typedef enum logic [1:0] {
    SEED   = 2'd0,
    CHECK  = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam int SEED_W = $clog2(POLY_LEN + 1);

  localparam logic [SEED_W-1:0] SEED_LAST  = SEED_W'(POLY_LEN - 1);
  localparam logic [7:0]        MATCH_LAST = 8'(LOCK_COUNT - 1);
  localparam logic [3:0]        MISS_LAST  = 4'(LOSS_COUNT - 1);
  localparam logic [ERR_W-1:0]  ERR_MAX    = '1;

  state_t              state;
  logic [POLY_LEN-1:0] sr;
  logic [SEED_W-1:0]   seed_cnt;
  logic [7:0]          match_cnt;
  logic [3:0]          miss_cnt;
  logic                locked;
  logic                err_pulse;
  logic                lock_lost;
  logic [ERR_W-1:0]    err_count;

  logic pred;
  logic lockup;
  logic mismatch;
  logic count_err;

  // Next-bit prediction, lockup detection and the error-count enable.
  always_comb begin
    // NOTE: every always_comb output is assigned on every path, so no latch can form.
    pred      = ~(sr[POLY_LEN-1] ^ sr[TAP_B-1]);
    lockup    = &sr;
    // The all-ones register is the XNOR lockup point and never a valid PRBS state.
    // Treating it as a miss keeps a stuck-at-1 stream from ever locking.
    mismatch  = lockup | (bus.in_bit ^ pred);
    count_err = bus.in_valid && (state == LOCKED) && mismatch;
  end

  // Seed / check / locked sequencing with registered status outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
      state     <= SEED;
      sr        <= '0;
      seed_cnt  <= '0;
      match_cnt <= '0;
      miss_cnt  <= '0;
      locked    <= 1'b0;
      err_pulse <= 1'b0;
      lock_lost <= 1'b0;
    end else begin
      err_pulse <= 1'b0;
      lock_lost <= 1'b0;
      if (bus.in_valid) begin
        unique case (state)
          SEED: begin
            sr <= {sr[POLY_LEN-2:0], bus.in_bit};
            if (seed_cnt == SEED_LAST) begin
              seed_cnt  <= '0;
              match_cnt <= '0;
              state     <= CHECK;
            end else begin
              seed_cnt <= seed_cnt + 1'b1;
            end
          end
          CHECK: begin
            sr <= {sr[POLY_LEN-2:0], bus.in_bit};
            if (mismatch) begin
              seed_cnt <= '0;
              state    <= SEED;
            end else if (match_cnt == MATCH_LAST) begin
              miss_cnt <= '0;
              locked   <= 1'b1;
              state    <= LOCKED;
            end else begin
              match_cnt <= match_cnt + 1'b1;
            end
          end
          LOCKED: begin
            // Free-run on the prediction so a single flipped bit is a single error.
            sr <= {sr[POLY_LEN-2:0], pred};
            if (mismatch) begin
              err_pulse <= 1'b1;
              if (miss_cnt == MISS_LAST) begin
                miss_cnt  <= '0;
                seed_cnt  <= '0;
                locked    <= 1'b0;
                lock_lost <= 1'b1;
                state     <= SEED;
              end else begin
                miss_cnt <= miss_cnt + 1'b1;
              end
            end else begin
              miss_cnt <= '0;
            end
          end
          default: begin
            seed_cnt <= '0;
            locked   <= 1'b0;
            state    <= SEED;
          end
        endcase
      end
    end
  end

  // Saturating error counter. A clear in the same cycle as an error leaves that error counted.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_count <= '0;
    end else if (bus.clear_cnt) begin
      err_count <= ERR_W'(count_err);
    end else if (count_err && (err_count != ERR_MAX)) begin
      err_count <= err_count + 1'b1;
    end
  end

  assign bus.locked    = locked;
  assign bus.err_pulse = err_pulse;
  assign bus.lock_lost = lock_lost;
  assign bus.err_count = err_count;

endmodule

// File: tb/tb_xnor_prbs_checker.sv
// Scoreboard bench for xnor_prbs_checker.
// Directed stimulus pushes hand-derived expected status for every clock.
// A monitor pops one entry per clock and compares it against the outputs after the edge.
module tb_xnor_prbs_checker;

  localparam int ERR_W = 4;

  typedef struct packed {
    logic             locked;
    logic             err_pulse;
    logic             lock_lost;
    logic [ERR_W-1:0] err_count;
  } obs_t;

  typedef struct packed {
    int   id;
    int   beat;
    obs_t exp;
  } sb_t;

  logic clk;
  logic rst_n;

  xnor_prbs_checker_if #(.ERR_W(ERR_W)) bus();

  xnor_prbs_checker #(.ERR_W(ERR_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  sb_t      exp_q[$];
  int       checks  = 0;
  int       errors  = 0;
  int       beat_no = 0;
  int       test_id = 0;
  logic [6:0] g;
  string    names[7] = '{"clean_lock", "single_err", "loss_relock", "const_one",
                         "idle_gaps", "clear_sat", "mid_reset"};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference PRBS7 stream source (XNOR of taps 7 and 6); the tests start it from 7'h00.
  task automatic next_bit(output logic b);
    b = ~(g[6] ^ g[5]);
    g = {g[5:0], b};
  endtask

  task automatic push_exp(input logic el, input logic ep, input logic ell, input int ec);
    sb_t e;
    beat_no++;
    e.id   = test_id;
    e.beat = beat_no;
    e.exp  = '{locked: el, err_pulse: ep, lock_lost: ell, err_count: ERR_W'(ec)};
    exp_q.push_back(e);
  endtask

  task automatic beat(input logic v, input logic b, input logic c,
                      input logic el, input logic ep, input logic ell, input int ec);
    @(negedge clk);
    rst_n        = 1'b1;
    bus.in_valid = v;
    bus.in_bit   = b;
    bus.clear_cnt = c;
    push_exp(el, ep, ell, ec);
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rst_n         = 1'b0;
      bus.in_valid  = 1'b1;
      bus.in_bit    = 1'b1;
      bus.clear_cnt = 1'b0;
      push_exp(1'b0, 1'b0, 1'b0, 0);
    end
  endtask

  // Lock from a fresh generator: locked rises after valid beat 23 (7 seed + 16 checks).
  task automatic fresh_lock(input int n);
    logic b;
    for (int k = 1; k <= n; k++) begin
      next_bit(b);
      beat(1'b1, b, 1'b0, k >= 23, 1'b0, 1'b0, 0);
    end
  endtask

  // Monitor: one expected entry per clock, compared after the edge has settled.
  initial begin
    sb_t  e;
    obs_t act;
    forever begin
      @(posedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        #2;
        act = '{locked: bus.locked, err_pulse: bus.err_pulse,
                lock_lost: bus.lock_lost, err_count: bus.err_count};
        checks++;
        if (act !== e.exp) begin
          errors++;
          $display("FAIL %s beat %0d: got locked=%b err_pulse=%b lock_lost=%b err_count=%0d, want locked=%b err_pulse=%b lock_lost=%b err_count=%0d",
                   names[e.id], e.beat, act.locked, act.err_pulse, act.lock_lost, act.err_count,
                   e.exp.locked, e.exp.err_pulse, e.exp.lock_lost, e.exp.err_count);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    logic b;
    logic e;
    int   cnt;

    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_bit    = 1'b0;
    bus.clear_cnt = 1'b0;

    // Clean lock, then 500 bits with no errors.
    test_id = 0;
    do_reset(2);
    g = '0;
    fresh_lock(500);

    // Single inverted bit while locked.
    test_id = 1;
    for (int k = 1; k <= 150; k++) begin
      next_bit(b);
      if (k == 100) b = ~b;
      beat(1'b1, b, 1'b0, 1'b1, k == 100, 1'b0, (k >= 100) ? 1 : 0);
    end

    // Four consecutive errors drop lock; the clean stream relocks after 23 beats.
    test_id = 2;
    do_reset(1);
    g = '0;
    fresh_lock(30);
    for (int k = 1; k <= 4; k++) begin
      next_bit(b);
      b = ~b;
      beat(1'b1, b, 1'b0, k < 4, 1'b1, k == 4, k);
    end
    for (int k = 1; k <= 40; k++) begin
      next_bit(b);
      beat(1'b1, b, 1'b0, k >= 23, 1'b0, 1'b0, 4);
    end

    // Constant ones sits in the XNOR lockup state and must never lock.
    test_id = 3;
    do_reset(1);
    for (int k = 1; k <= 200; k++)
      beat(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0);

    // Valid beats alternating with idle beats carrying junk bits.
    test_id = 4;
    do_reset(1);
    g = '0;
    for (int k = 1; k <= 30; k++) begin
      next_bit(b);
      beat(1'b1, b, 1'b0, k >= 23, 1'b0, 1'b0, 0);
      beat(1'b0, ~b, 1'b0, k >= 23, 1'b0, 1'b0, 0);
    end

    // Every 8th bit inverted saturates a 4-bit counter; then the clear cases.
    test_id = 5;
    do_reset(1);
    g = '0;
    fresh_lock(30);
    cnt = 0;
    for (int k = 1; k <= 160; k++) begin
      next_bit(b);
      e = (k % 8 == 0);
      if (e) begin
        b = ~b;
        if (cnt < 15) cnt++;
      end
      beat(1'b1, b, 1'b0, 1'b1, e, 1'b0, cnt);
    end
    next_bit(b);
    beat(1'b1, ~b, 1'b1, 1'b1, 1'b1, 1'b0, 1);
    next_bit(b);
    beat(1'b1, b, 1'b1, 1'b1, 1'b0, 1'b0, 0);
    next_bit(b);
    beat(1'b1, ~b, 1'b0, 1'b1, 1'b1, 1'b0, 1);
    beat(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0);

    // Reset while locked with three errors counted, then relock.
    test_id = 6;
    do_reset(1);
    g = '0;
    fresh_lock(30);
    cnt = 0;
    for (int k = 1; k <= 10; k++) begin
      next_bit(b);
      e = (k == 2) || (k == 4) || (k == 6);
      if (e) begin
        b = ~b;
        cnt++;
      end
      beat(1'b1, b, 1'b0, 1'b1, e, 1'b0, cnt);
    end
    do_reset(1);
    for (int k = 1; k <= 30; k++) begin
      next_bit(b);
      beat(1'b1, b, 1'b0, k >= 23, 1'b0, 1'b0, 0);
    end

    @(negedge clk);
    rst_n        = 1'b1;
    bus.in_valid = 1'b0;
    bus.clear_cnt = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected entries left unchecked, want 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
